card_match_core: RTL
====================

Name: card_match_core

Overview:
- Parametrised game engine for the card-match memory game: deck init, sequential shuffle, preview, pick/compare, mismatch hold, win detection.
- Grid size, symbol width and all timings are parameters.
- Sits between the debounced button edge detectors and the VGA renderer/7-seg/buzzer drivers.
- The renderer reads card faces through a dedicated read port; no VGA logic lives here.

Parameters:
- COLS, 4, grid columns (>=2)
- ROWS, 4, grid rows; COLS*ROWS must be even
- SYM_W, 3, symbol width; 2**SYM_W >= COLS*ROWS/2
- PREVIEW_CYCLES, 100_000_000, all-cards-shown time after shuffle
- MISMATCH_CYCLES, 20_000_000, hold time of a wrong pair before closing
- LFSR_SEED, 16'hACE1, nonzero reset seed of the shuffle LFSR
- MOVE_W, 8, move counter width

Ports:
- clk  in  1  system clock
- reset  in  1  sync active-high
- up_p, down_p, left_p, right_p, sel_p  in  1 each  single-cycle debounced edge pulses
- rd_addr  in  IDX_W  renderer card index (IDX_W = clog2(COLS*ROWS))
- rd_face  out  SYM_W  symbol at rd_addr, registered, 1-cycle latency
- open_mask  out  COLS*ROWS  1 = card face up
- cursor  out  IDX_W  selected card index
- cursor_vis  out  1  high in PICK1/PICK2/MISMATCH
- pairs  out  IDX_W  matched pairs
- moves  out  MOVE_W  completed pair attempts, saturating
- mismatch_p  out  1  one-cycle pulse on wrong pair (buzzer trigger)
- won  out  1  high in WON
- state_o  out  3  current state encoding

Behaviour:
- Reset: state IDLE; open_mask 0; cursor 0; pairs 0; moves 0; mismatch_p 0; won 0; rd_face 0; LFSR = LFSR_SEED. LFSR (16-bit Galois, taps 16,14,13,11) advances every cycle in all states, so the press time seeds the shuffle.
- IDLE: on sel_p, load deck[k] = k>>1, set i = N-1, go to SHUFFLE.
- SHUFFLE: one candidate per cycle. j = LFSR low IDX_W bits. If j <= i, swap deck[i]/deck[j] and decrement i; otherwise reject and retry next cycle. After the i==1 swap, set open_mask all ones and go to PREVIEW. Buttons are ignored.
- PREVIEW: count PREVIEW_CYCLES cycles, then clear open_mask and go to PICK1.
- Cursor moves in PICK1, PICK2 and MISMATCH only.
  - Priority: up > down > left > right; at most one move per cycle.
  - Moves are clamped at grid edges, with no wrap.
  - up: cursor-COLS if row>0. down: +COLS if row<ROWS-1. left/right: ±1 within the row.
- PICK1: sel_p on a closed card sets its mask bit, latches first = cursor, goes to PICK2. sel_p on an open card is ignored.
- PICK2: sel_p on a closed card sets its mask bit and increments moves.
  - Match (deck equal): pairs+1. If pairs becomes N/2, go to WON; else go to PICK1.
  - Mismatch: pulse mismatch_p, latch second = cursor, go to MISMATCH.
- MISMATCH: count MISMATCH_CYCLES, then clear the mask bits of first and second (latched indices, not cursor) and go to PICK1. sel_p is ignored.
- WON: won=1. sel_p clears open_mask, pairs and moves, sets cursor 0, goes to IDLE. The deck is kept until the next shuffle.
- Simultaneous sel_p and a direction: the selection uses the pre-move cursor.
- moves saturates at 2**MOVE_W-1.
- reset in any state, including mid-SHUFFLE or mid-count, restores all reset values. Deck contents are then don't-care until the next shuffle.
- Timers are sized to clog2(max(PREVIEW_CYCLES, MISMATCH_CYCLES)+1) bits, and each timer clears on state entry.

Optional Feature:
- Macro: CARD_MATCH_MOVE_LIMIT_EN.
- With the macro:
  - Adds parameter MAX_MOVES (default 24), output lost (1), and state LOST.
  - When the increment in PICK2 makes moves == MAX_MOVES without completing the game, go to LOST with open_mask all ones.
  - A winning final pair takes priority over LOST.
  - LOST: sel_p behaves as in WON.
- Without the macro: no lost port, no LOST state, unlimited moves up to saturation.

Decomposition:
- card_match_pkg holds:
  - state enum: IDLE=0, SHUFFLE=1, PREVIEW=2, PICK1=3, PICK2=4, MISMATCH=5, WON=6, LOST=7
  - LFSR tap constant
  - idx_w(cols, rows) function
- One sub-module: card_match_lfsr16 (seed parameter, free-running, 16-bit output).

Test Plan:
- Fixed seed, sel_p at cycle 10, PREVIEW_CYCLES=50: SHUFFLE ends with deck a permutation holding each symbol 0..7 exactly twice. open_mask=16'hFFFF for 50 cycles, then 0 in PICK1.
- Matching pair (find via rd_addr) selected: pairs 0->1, moves 0->1, both bits stay set, back in PICK1. Reselecting an open card changes nothing.
- Mismatching pair, MISMATCH_CYCLES=20: mismatch_p for exactly 1 cycle. Cursor moved during the hold; after 20 cycles exactly the two picked bits clear.
- Cursor at 0: up_p and left_p leave it at 0. down_p×5 reaches 12, not beyond. up_p+right_p in the same cycle: up wins.
- All 8 pairs matched: won=1 and state WON. sel_p returns to IDLE with pairs=moves=0. reset asserted mid-SHUFFLE returns every output to its reset value next cycle.
- With CARD_MATCH_MOVE_LIMIT_EN and MAX_MOVES=3: three mismatches set lost=1 and open_mask=all ones; sel_p returns to IDLE.

Source files
------------

// File: rtl/card_match_pkg.sv
// Shared types and constants for the card-match game engine.
package card_match_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHUFFLE  = 3'd1,
        ST_PREVIEW  = 3'd2,
        ST_PICK1    = 3'd3,
        ST_PICK2    = 3'd4,
        ST_MISMATCH = 3'd5,
        ST_WON      = 3'd6,
        ST_LOST     = 3'd7
    } state_t;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int idx_w(input int cols, input int rows);
        return (cols * rows > 1) ? $clog2(cols * rows) : 1;
    endfunction

endpackage

// File: rtl/card_match_lfsr16.sv
// Free-running 16-bit Galois LFSR; the press time of the start button picks the shuffle.
module card_match_lfsr16
    import card_match_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] o_lfsr
);

    logic [15:0] r_lfsr;

    always_ff @(posedge clk) begin
        if (reset)
            r_lfsr <= SEED;
        else
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/card_match_core.sv
// Card-match memory game engine: deck shuffle, preview, pick/compare, mismatch hold, win.
// Optional move limit (LOST state, o_lost port) enabled by CARD_MATCH_MOVE_LIMIT_EN.
module card_match_core
    import card_match_pkg::*;
#(
    parameter int          COLS            = 4,
    parameter int          ROWS            = 4,
    parameter int          SYM_W           = 3,
    parameter int          PREVIEW_CYCLES  = 100_000_000,
    parameter int          MISMATCH_CYCLES = 20_000_000,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1,
    parameter int          MOVE_W          = 8,
`ifdef CARD_MATCH_MOVE_LIMIT_EN
    parameter int          MAX_MOVES       = 24,
`endif
    localparam int         N               = COLS * ROWS,
    localparam int         IDX_W           = idx_w(COLS, ROWS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_up_p,
    input  logic              i_down_p,
    input  logic              i_left_p,
    input  logic              i_right_p,
    input  logic              i_sel_p,
    input  logic [IDX_W-1:0]  i_rd_addr,
    output logic [SYM_W-1:0]  o_rd_face,
    output logic [N-1:0]      o_open_mask,
    output logic [IDX_W-1:0]  o_cursor,
    output logic              o_cursor_vis,
    output logic [IDX_W-1:0]  o_pairs,
    output logic [MOVE_W-1:0] o_moves,
    output logic              o_mismatch_p,
    output logic              o_won,
`ifdef CARD_MATCH_MOVE_LIMIT_EN
    output logic              o_lost,
`endif
    output logic [2:0]        o_state
);

    localparam int TMAX = (PREVIEW_CYCLES > MISMATCH_CYCLES) ? PREVIEW_CYCLES : MISMATCH_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    state_t             r_state, w_next;
    logic [15:0]        w_lfsr;
    logic               w_unused_lfsr;
    logic [SYM_W-1:0]   r_deck [N];
    logic [IDX_W-1:0]   r_i, r_first, r_second, r_row, r_col;
    logic [N-1:0]       r_mask;
    logic [IDX_W-1:0]   r_pairs;
    logic [MOVE_W-1:0]  r_moves;
    logic [TW-1:0]      r_timer;
    logic               r_mm_p;
    logic [SYM_W-1:0]   r_rd_face;

    logic [IDX_W-1:0]   w_cursor, w_j;
    logic               w_swap, w_sel_closed, w_match, w_win, w_move_en;
    logic               w_prev_done, w_mm_done;
    logic [MOVE_W-1:0]  w_moves_inc;

    card_match_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .o_lfsr (w_lfsr)
    );

    assign w_unused_lfsr = ^w_lfsr[15:IDX_W];
    assign w_j           = w_lfsr[IDX_W-1:0];
    assign w_cursor      = IDX_W'(int'(r_row) * COLS + int'(r_col));
    assign w_swap        = (r_state == ST_SHUFFLE) && (w_j <= r_i);
    // Selection always acts on the pre-move cursor
    assign w_sel_closed  = i_sel_p && !r_mask[w_cursor];
    assign w_match       = (r_deck[r_first] == r_deck[w_cursor]);
    assign w_win         = w_match && (r_pairs == IDX_W'(N / 2 - 1));
    assign w_moves_inc   = (r_moves == '1) ? r_moves : r_moves + 1'b1;
    assign w_move_en     = (r_state inside {ST_PICK1, ST_PICK2, ST_MISMATCH});
    assign w_prev_done   = (r_timer == TW'(PREVIEW_CYCLES - 1));
    assign w_mm_done     = (r_timer == TW'(MISMATCH_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (i_sel_p) w_next = ST_SHUFFLE;
            ST_SHUFFLE:  if (w_swap && r_i == IDX_W'(1)) w_next = ST_PREVIEW;
            ST_PREVIEW:  if (w_prev_done) w_next = ST_PICK1;
            ST_PICK1:    if (w_sel_closed) w_next = ST_PICK2;
            ST_PICK2: begin
                if (w_sel_closed) begin
                    if (w_win)                                    w_next = ST_WON;
`ifdef CARD_MATCH_MOVE_LIMIT_EN
                    else if (w_moves_inc == MOVE_W'(MAX_MOVES))   w_next = ST_LOST;
`endif
                    else if (w_match)                             w_next = ST_PICK1;
                    else                                          w_next = ST_MISMATCH;
                end
            end
            ST_MISMATCH: if (w_mm_done) w_next = ST_PICK1;
            ST_WON:      if (i_sel_p) w_next = ST_IDLE;
`ifdef CARD_MATCH_MOVE_LIMIT_EN
            ST_LOST:     if (i_sel_p) w_next = ST_IDLE;
`endif
            default:     w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_state      = r_state;
        o_cursor_vis = w_move_en;
        o_won        = (r_state == ST_WON);
`ifdef CARD_MATCH_MOVE_LIMIT_EN
        o_lost       = (r_state == ST_LOST);
`endif
    end

    // Deck contents are don't-care after reset, so no reset branch here
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && i_sel_p) begin
            for (int k = 0; k < N; k++) r_deck[k] <= SYM_W'(k >> 1);
        end else if (w_swap) begin
            r_deck[r_i] <= r_deck[w_j];
            r_deck[w_j] <= r_deck[r_i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask    <= '0;
            r_row     <= '0;
            r_col     <= '0;
            r_pairs   <= '0;
            r_moves   <= '0;
            r_mm_p    <= 1'b0;
            r_rd_face <= '0;
            r_timer   <= '0;
            r_i       <= '0;
            r_first   <= '0;
            r_second  <= '0;
        end else begin
            r_mm_p    <= 1'b0;
            r_rd_face <= r_deck[i_rd_addr];
            if (r_state != w_next)
                r_timer <= '0;
            else if (r_state == ST_PREVIEW || r_state == ST_MISMATCH)
                r_timer <= r_timer + 1'b1;

            if (w_move_en) begin
                if (i_up_p)         begin if (r_row != '0)                  r_row <= r_row - 1'b1; end
                else if (i_down_p)  begin if (r_row != IDX_W'(ROWS - 1))    r_row <= r_row + 1'b1; end
                else if (i_left_p)  begin if (r_col != '0)                  r_col <= r_col - 1'b1; end
                else if (i_right_p) begin if (r_col != IDX_W'(COLS - 1))    r_col <= r_col + 1'b1; end
            end

            case (r_state)
                ST_IDLE:    if (i_sel_p) r_i <= IDX_W'(N - 1);
                ST_SHUFFLE: begin
                    if (w_swap) r_i <= r_i - 1'b1;
                    if (w_next == ST_PREVIEW) r_mask <= '1;
                end
                ST_PREVIEW: if (w_prev_done) r_mask <= '0;
                ST_PICK1: begin
                    if (w_sel_closed) begin
                        r_mask[w_cursor] <= 1'b1;
                        r_first          <= w_cursor;
                    end
                end
                ST_PICK2: begin
                    if (w_sel_closed) begin
                        r_mask[w_cursor] <= 1'b1;
                        r_moves          <= w_moves_inc;
                        if (w_match) begin
                            r_pairs <= r_pairs + 1'b1;
                        end else begin
                            r_mm_p   <= 1'b1;
                            r_second <= w_cursor;
                        end
`ifdef CARD_MATCH_MOVE_LIMIT_EN
                        if (w_next == ST_LOST) r_mask <= '1;
`endif
                    end
                end
                ST_MISMATCH: begin
                    if (w_mm_done) begin
                        r_mask[r_first]  <= 1'b0;
                        r_mask[r_second] <= 1'b0;
                    end
                end
                ST_WON, ST_LOST: begin
                    if (i_sel_p) begin
                        r_mask  <= '0;
                        r_pairs <= '0;
                        r_moves <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rd_face    = r_rd_face;
    assign o_open_mask  = r_mask;
    assign o_cursor     = w_cursor;
    assign o_pairs      = r_pairs;
    assign o_moves      = r_moves;
    assign o_mismatch_p = r_mm_p;

endmodule
